ascii_dec_parser: RTL and testbench
===================================

// Module: ascii_dec_parser
//
// PURPOSE
//   Streaming consumer of 7-bit ASCII characters that converts runs of decimal
//   digits into unsigned binary numbers.
//   - Sits downstream of the char_type classifier: a character stream goes in,
//     one number comes out per digit run.
//   - Uses char_type's is_num flag to separate digits from delimiters.
//   - Valid/ready handshake on both the input side and the output side.
//
// PARAMETERS
//   WIDTH  16  width of the binary result (unsigned, saturating)
//   CNT_W  4   width of the digit-count output (saturating)
//
// PORTS
//   clk        in   1      single clock; all state on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      in_code/in_last are valid this cycle
//   in_ready   out  1      block accepts a character this cycle
//   in_code    in   7      ASCII character
//   in_last    in   1      last character of the stream; forces a flush
//   out_valid  out  1      a number is presented
//   out_ready  in   1      downstream accepts the number
//   out_data   out  WIDTH  parsed value
//   out_digits out  CNT_W  digits in the run, saturating at 2**CNT_W-1
//   out_ovf    out  1      value exceeded 2**WIDTH-1; out_data is all ones
//
// BEHAVIOUR
//   - Reset (sync, active-high): state=IDLE, acc=0, cnt=0, ovf=0.
//     Outputs after reset: in_ready=1, out_valid=0, out_data=0,
//     out_digits=0, out_ovf=0. Reset mid-run discards the partial number.
//   - Accept: a character is taken when in_valid && in_ready.
//     in_ready = (state != EMIT).
//   - Digit test: is_num from the char_type instance, d = in_code - 7'h30.
//   - FSM, evaluated on an accepted character:
//     IDLE:
//       digit, !in_last -> acc=d, cnt=1, ovf=0, go to ACCUM.
//       digit,  in_last -> same load, go to EMIT.
//       non-digit       -> discarded, stay in IDLE (leading delimiters and
//                          non-printables are ignored).
//     ACCUM:
//       digit     -> acc = acc*10 + d; cnt = sat(cnt+1).
//                    If in_last, go to EMIT.
//       non-digit -> go to EMIT. The delimiter is consumed, not re-used.
//     EMIT:
//       in_ready=0 and out_valid=1. out_data, out_digits and out_ovf hold
//       registered values, stable until out_valid && out_ready.
//       On that handshake -> IDLE, outputs return to 0.
//   - Arithmetic: compute acc*10 + d in WIDTH+4 bits.
//     If the result exceeds 2**WIDTH-1: ovf is set (sticky for the run) and
//     acc is forced to all ones. Once ovf is set, further digits keep
//     acc=all ones.
//   - Latency: the terminating character is accepted in cycle N; out_valid
//     is high in cycle N+1.
//     Throughput: one number per run plus one EMIT handshake cycle minimum.
//   - A non-digit in_last character seen in IDLE produces no output.
//   - out_ready while out_valid=0 is ignored.
//   - in_valid while in_ready=0 leaves the character pending upstream (not
//     consumed).
//
// STRUCTURE
//   - ascii_pkg: ASCII_ZERO=7'h30, DEC_BASE=10, and
//     typedef enum logic [1:0] {IDLE, ACCUM, EMIT} parse_state_t.
//   - Sub-module: char_type, one instance, fed by in_code; only is_num is used.
//   - Body: one always_ff for state, acc, cnt, ovf; one always_comb for
//     next-state and the multiply-add.
//
// TESTING (WIDTH=16 unless stated)
//   1. "123 " streamed, out_ready=1 -> one output: out_data=123,
//      out_digits=3, out_ovf=0.
//   2. WIDTH=8, "300," -> out_data=8'hFF, out_ovf=1, out_digits=3;
//      then "25," -> out_data=25, out_ovf=0.
//   3. "ab \n" then "x" -> out_valid never asserts; in_ready stays 1.
//   4. "7;8;" with out_ready=0 for 5 cycles after ';' -> out_valid=1 and
//      out_data=7 stable, in_ready=0, '8' not consumed.
//      After out_ready=1 -> 7, then 8.
//   5. "42" with in_last on '2' -> out_data=42 one cycle after '2' is
//      accepted, with no delimiter sent.
//   6. "9" accepted, rst pulsed 1 cycle -> all outputs 0, state IDLE;
//      then "5 " -> out_data=5, out_digits=1.

Source files
------------

// File: rtl/ascii_pkg.sv
// ascii_pkg: shared constants and state encoding for the ASCII decimal parser
package ascii_pkg;
  localparam logic [6:0] ASCII_ZERO = 7'h30;
  localparam int DEC_BASE = 10;
  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} parse_state_t;
endpackage

// File: rtl/char_type.sv
// char_type: classifies a 7-bit ASCII code; flags decimal digits
module char_type
  import ascii_pkg::*;
(
  input  logic [6:0] code,
  output logic       is_num
);
  assign is_num = code >= ASCII_ZERO && code <= ASCII_ZERO + 7'd9;
endmodule

// File: rtl/ascii_dec_parser.sv
// ascii_dec_parser: turns runs of ASCII decimal digits into saturating binary numbers
module ascii_dec_parser
  import ascii_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_code,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_digits,
  output logic             out_ovf
);
  parse_state_t state, state_n;
  logic [WIDTH-1:0] acc, acc_n, base;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic ovf, ovf_n, is_num, take, sat;
  logic [3:0] d;
  logic [WIDTH+3:0] mac;
  char_type u_char_type (.code(in_code), .is_num(is_num));
  assign take = in_valid && in_ready;
  assign d = 4'(in_code - ASCII_ZERO);
  always_comb begin
    state_n = state;
    acc_n = acc;
    cnt_n = cnt;
    ovf_n = ovf;
    base = state == ACCUM ? acc : '0;
    mac = (WIDTH+4)'(base) * (WIDTH+4)'(DEC_BASE) + (WIDTH+4)'(d);
    // once a run has overflowed, it stays pinned at all ones
    sat = (state == ACCUM && ovf) || |mac[WIDTH+3:WIDTH];
    if (take && is_num) begin
      acc_n = sat ? '1 : mac[WIDTH-1:0];
      cnt_n = state == IDLE ? CNT_W'(1) : (&cnt ? cnt : cnt + 1'b1);
      ovf_n = sat;
      state_n = in_last ? EMIT : ACCUM;
    end else if (take && state == ACCUM) begin
      state_n = EMIT;
    end else if (state == EMIT && out_ready) begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      out_data <= '0;
      out_digits <= '0;
      out_ovf <= 1'b0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      cnt <= cnt_n;
      ovf <= ovf_n;
      in_ready <= state_n != EMIT;
      out_valid <= state_n == EMIT;
      out_data <= state_n == EMIT ? acc_n : '0;
      out_digits <= state_n == EMIT ? cnt_n : '0;
      out_ovf <= state_n == EMIT && ovf_n;
    end
  end
endmodule

// File: tb/tb_ascii_dec_parser.sv
// tb_ascii_dec_parser: scoreboard bench driving 16-bit and 8-bit parsers with one stream
module tb_ascii_dec_parser;
  typedef struct {
    int data;
    int digits;
    bit ovf;
  } exp_t;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 1;
  logic [6:0] in_code = '0;
  logic r16, v16, o16, r8, v8, o8;
  logic [15:0] d16;
  logic [7:0] d8;
  logic [3:0] g16, g8;
  exp_t q16[$], q8[$];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  ascii_dec_parser #(.WIDTH(16), .CNT_W(4)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r16), .in_code(in_code),
    .in_last(in_last), .out_valid(v16), .out_ready(out_ready), .out_data(d16),
    .out_digits(g16), .out_ovf(o16)
  );
  ascii_dec_parser #(.WIDTH(8), .CNT_W(4)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r8), .in_code(in_code),
    .in_last(in_last), .out_valid(v8), .out_ready(out_ready), .out_data(d8),
    .out_digits(g8), .out_ovf(o8)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  task automatic expect2(input int a16, input int n16, input bit f16,
                         input int a8, input int n8, input bit f8);
    q16.push_back('{a16, n16, f16});
    q8.push_back('{a8, n8, f8});
  endtask
  task automatic put(input logic [6:0] c, input logic l);
    int n = 0;
    in_valid = 1;
    in_code = c;
    in_last = l;
    @(negedge clk);
    while (!r16) begin
      n++;
      if (n > 50) begin
        chk("put_timeout", 0, 1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic send(input string s, input bit last);
    for (int i = 0; i < s.len(); i++) put(7'(s[i]), last && i == s.len() - 1);
  endtask
  task automatic idle_outputs(input string tag);
    chk({tag, "_valid16"}, int'(v16), 0);
    chk({tag, "_data16"}, int'(d16), 0);
    chk({tag, "_digits16"}, int'(g16), 0);
    chk({tag, "_ovf16"}, int'(o16), 0);
    chk({tag, "_ready16"}, int'(r16), 1);
    chk({tag, "_valid8"}, int'(v8), 0);
    chk({tag, "_ready8"}, int'(r8), 1);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst && v16 && out_ready) begin
      if (q16.size() == 0) chk("u16_unexpected_output", int'(d16), -1);
      else begin
        e = q16.pop_front();
        chk("u16_data", int'(d16), e.data);
        chk("u16_digits", int'(g16), e.digits);
        chk("u16_ovf", int'(o16), int'(e.ovf));
      end
    end
    if (!rst && v8 && out_ready) begin
      if (q8.size() == 0) chk("u8_unexpected_output", int'(d8), -1);
      else begin
        e = q8.pop_front();
        chk("u8_data", int'(d8), e.data);
        chk("u8_digits", int'(g8), e.digits);
        chk("u8_ovf", int'(o8), int'(e.ovf));
      end
    end
  end
  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    idle_outputs("reset");
    expect2(123, 3, 0, 123, 3, 0);
    send("123 ", 0);
    chk("latency_123", int'(v16), 1);
    expect2(300, 3, 0, 255, 3, 1);
    expect2(25, 2, 0, 25, 2, 0);
    send("300,25,", 0);
    send("ab \n", 0);
    send("x", 1);
    repeat (3) @(posedge clk);
    #1 idle_outputs("nondigit");
    out_ready = 0;
    expect2(7, 1, 0, 7, 1, 0);
    expect2(8, 1, 0, 8, 1, 0);
    send("7;", 0);
    fork
      put(7'h38, 0);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("hold_valid", int'(v16), 1);
          chk("hold_data", int'(d16), 7);
          chk("hold_ready", int'(r16), 0);
        end
        @(posedge clk);
        #1 out_ready = 1;
      end
    join
    send(";", 0);
    expect2(42, 2, 0, 42, 2, 0);
    send("42", 1);
    chk("latency_last", int'(v16), 1);
    expect2(65535, 5, 0, 255, 5, 1);
    expect2(65535, 5, 1, 255, 5, 1);
    expect2(255, 3, 0, 255, 3, 0);
    expect2(256, 3, 0, 255, 3, 1);
    expect2(7, 3, 0, 7, 3, 0);
    expect2(65535, 15, 1, 255, 15, 1);
    send("65535 65536 255,256,007 12345678901234567.", 0);
    put(7'h39, 0);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    idle_outputs("midrun_reset");
    expect2(5, 1, 0, 5, 1, 0);
    send("5 ", 0);
    n = 0;
    while ((q16.size() != 0 || q8.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("u16_pending", q16.size(), 0);
    chk("u8_pending", q8.size(), 0);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
